// File: rtl/fpm_pkg.sv
// Shared sizing and tag record for the floating-point multiplier arbiter.
package fpm_pkg;

    localparam int NUM_REQ = 4;
    localparam int LAT     = 2;
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // One in-flight operation: whether the slot is live and who owns the result.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping; one-hot out.
module rr_arbiter
    import fpm_pkg::*;
#(
    parameter int N_REQ = NUM_REQ,
    parameter int PTR_W = IDX_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        // Outer loop walks priority order; inner loop keeps every bit select constant.
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N_REQ)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpm_arbiter.sv
// Shares one external pipelined FP multiplier among NUM_REQ requesters and
// routes each registered product back to its owner via a tag pipeline.
module fpm_arbiter #(
    parameter int NUM_REQ = fpm_pkg::NUM_REQ,
    parameter int LAT     = fpm_pkg::LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_zero_a,
    input  logic [NUM_REQ-1:0]    req_zero_b,
    output logic [31:0]           fpm_a,
    output logic [31:0]           fpm_b,
    output logic                  fpm_zero_a,
    output logic                  fpm_zero_b,
    input  logic [31:0]           fpm_product,
    input  logic                  fpm_zero_out,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_product,
    output logic                  resp_zero,
    output logic                  busy,
    output logic [15:0]           issue_count
);

    // The tag record is sized by the package, so NUM_REQ must match fpm_pkg::NUM_REQ.
    localparam int IW = fpm_pkg::IDX_W;
    typedef fpm_pkg::tag_t tag_t;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]        issue_count_q, issue_count_d;
    tag_t               tag_q [LAT];
    tag_t               tag_d [LAT];
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gnt_idx;
    logic               handshake;

    rr_arbiter #(
        .N_REQ (NUM_REQ),
        .PTR_W (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // Masking with rst keeps ready low while reset is held.
    assign req_ready = grant & {NUM_REQ{rst}};
    assign handshake = |req_ready;

    always_comb begin
        gnt_idx    = '0;
        fpm_a      = '0;
        fpm_b      = '0;
        fpm_zero_a = 1'b0;
        fpm_zero_b = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx    = IW'(i);
                fpm_a      = req_a[32*i +: 32];
                fpm_b      = req_b[32*i +: 32];
                fpm_zero_a = req_zero_a[i];
                fpm_zero_b = req_zero_b[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        issue_count_d = issue_count_q;
        if (handshake) begin
            rr_ptr_d      = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            issue_count_d = issue_count_q + 16'd1;
        end
        tag_d[0].valid = handshake;
        tag_d[0].idx   = gnt_idx;
        for (int s = 1; s < LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q      <= '0;
            issue_count_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            issue_count_q <= issue_count_d;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // The last tag stage lines up with the multiplier's registered product.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
        assign resp_valid[gi] = tag_q[LAT-1].valid && (int'(tag_q[LAT-1].idx) == gi);
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

    assign resp_product = fpm_product;
    assign resp_zero    = fpm_zero_out;
    assign issue_count  = issue_count_q;

endmodule
